// File: rtl/ha_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
package ha_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/half_adder.sv
// 1-bit half adder; two of these plus an OR form the serial full-add step.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/ha_serial_adder_ctrl.sv
// Bit-serial adder: LSB first, one bit per clock through a shared full-add step.
module ha_serial_adder_ctrl
    import ha_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] res_q;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;

    logic             s0, c0, s1, c1;
    logic             carry_d;
    logic [WIDTH-1:0] res_d;

    half_adder u_ha0 (
        .a (a_q[0]),
        .b (b_q[0]),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (carry_q),
        .s (s1),
        .c (c1)
    );

    assign carry_d = c0 | c1;
    // The result register keeps only the upper WIDTH-1 bits; the final edge
    // publishes the full word including the bit produced on that edge.
    assign res_d   = {s1, res_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_d[WIDTH-1:1];
                    carry_q <= carry_d;
                    if (cnt_q == LastBit) begin
                        sum     <= res_d;
                        cout    <= carry_d;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ha_serial_adder_ctrl.sv
// Scoreboard bench: a WIDTH=8 and a WIDTH=2 instance checked against a + b.
module tb_ha_serial_adder_ctrl;

    typedef struct {
        logic [32:0] val;
        int          dc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v [2];
    logic [31:0] a_v [2];
    logic [31:0] b_v [2];
    int          ops [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar i = 0; i < 2; i++) begin : g_inst
        localparam int W = (i == 0) ? 8 : 2;

        logic         busy, done, cout;
        logic [W-1:0] sum;
        exp_t         q[$];
        int           cy = 0;
        int           free_edge = 0;
        int           busy_lo = 0;
        int           busy_hi = -1;
        logic [32:0]  held = '0;

        ha_serial_adder_ctrl #(.WIDTH(W)) dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_v[i]),
            .a     (a_v[i][W-1:0]),
            .b     (b_v[i][W-1:0]),
            .busy  (busy),
            .done  (done),
            .sum   (sum),
            .cout  (cout)
        );

        // Reference: an accepted start yields a + b after W edges, busy from
        // the accepting edge through the done cycle, next accept W+2 edges on.
        always @(posedge clk) begin
            logic [32:0] e;
            cy = cy + 1;
            if (rst) begin
                q.delete();
                free_edge = cy + 1;
                busy_lo   = 0;
                busy_hi   = -1;
            end else if (start_v[i] && cy >= free_edge) begin
                e = 33'(a_v[i][W-1:0]) + 33'(b_v[i][W-1:0]);
                q.push_back('{val: e, dc: cy + W});
                busy_lo   = cy;
                busy_hi   = cy + W;
                free_edge = cy + W + 2;
                ops[i]    = ops[i] + 1;
            end
        end

        always @(negedge clk) begin
            if (rst) begin
                chk($sformatf("w%0d reset outputs", W), {29'd0, busy, done, cout, 1'b0} |
                    33'(sum), 33'd0);
                held = '0;
            end else begin
                if (q.size() > 0 && q[0].dc < cy) begin
                    chk($sformatf("w%0d missed done", W), 33'(cy), 33'(q[0].dc));
                    void'(q.pop_front());
                end
                chk($sformatf("w%0d busy", W), 33'(busy),
                    33'(cy >= busy_lo && cy <= busy_hi));
                if (done) begin
                    if (q.size() == 0) begin
                        chk($sformatf("w%0d unexpected done", W), 33'(done), 33'd0);
                    end else begin
                        chk($sformatf("w%0d done cycle", W), 33'(cy), 33'(q[0].dc));
                        held = q[0].val;
                        void'(q.pop_front());
                    end
                end
                chk($sformatf("w%0d result", W), {cout, sum}, held);
            end
        end
    end

    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0]     = {24'd0, a};
        b_v[0]     = {24'd0, b};
        @(negedge clk);
        start_v[0] = 1'b0;
        a_v[0]     = $urandom;
        b_v[0]     = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        int base0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            a_v[i]     = '0;
            b_v[i]     = '0;
            ops[i]     = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        launch(8'h03, 8'h05);
        repeat (12) @(negedge clk);
        launch(8'hFF, 8'h01);
        repeat (12) @(negedge clk);

        // Re-pulse while busy must be ignored.
        launch(8'h12, 8'h34);
        repeat (3) @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0]     = 32'hAA;
        b_v[0]     = 32'h55;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (10) @(negedge clk);

        // Abort mid-operation with an asynchronous reset.
        launch(8'h0F, 8'h0F);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        launch(8'h10, 8'h20);
        repeat (12) @(negedge clk);

        // Start held high; operands churn every cycle.
        @(negedge clk);
        start_v[0] = 1'b1;
        for (int k = 0; k < 32; k++) begin
            a_v[0] = $urandom;
            b_v[0] = $urandom;
            @(negedge clk);
        end
        start_v[0] = 1'b0;
        repeat (12) @(negedge clk);

        base0 = ops[0];
        guard = 0;
        while ((ops[0] < base0 + 1000 || ops[1] < 1000) && guard < 40000) begin
            for (int i = 0; i < 2; i++) begin
                start_v[i] = ($urandom_range(0, 3) != 0);
                a_v[i]     = $urandom;
                b_v[i]     = $urandom;
            end
            @(negedge clk);
            guard++;
        end
        chk("random op budget", 33'(guard < 40000), 33'd1);
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        repeat (15) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
